// File: rtl/tof_pkg.sv
// Shared defaults, FSM state type and BRAM address packing for the ToF frame collector.
package tof_pkg;

    localparam int N_CH_DEF   = 8;
    localparam int ZONES_DEF  = 64;
    localparam int DIST_W_DEF = 16;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    // Address layout is {bank, channel, zone}; callers truncate to their own width.
    function automatic logic [31:0] pack_addr(input logic bank, input int ch, input int zone,
                                              input int ch_w, input int zone_w);
        return ({31'd0, bank} << (ch_w + zone_w)) | (32'(ch) << zone_w) | 32'(zone);
    endfunction

endpackage

// File: rtl/tof_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; pointer moves past the winner on advance.
module tof_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx, idx;

    // Scan from farthest to nearest so the nearest requester is the last assignment to stick.
    always_comb begin
        grant_o = '0;
        gidx    = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                gidx         = idx;
            end
        end
    end

    assign ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tof_frame_collector.sv
// Collects per-channel ToF zone samples into a ping-pong BRAM frame buffer and hands
// completed frames to the reader, counting frames that arrive while the reader is busy.
module tof_frame_collector
    import tof_pkg::*;
#(
    parameter  int N_CH   = N_CH_DEF,
    parameter  int ZONES  = ZONES_DEF,
    parameter  int DIST_W = DIST_W_DEF,
    localparam int ZONE_W = $clog2(ZONES),
    localparam int CH_W   = $clog2(N_CH),
    localparam int AW     = 1 + CH_W + ZONE_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_CH-1:0]          ch_en_i,
    input  logic [N_CH-1:0]          ch_valid_i,
    input  logic [N_CH*ZONE_W-1:0]   ch_zone_i,
    input  logic [N_CH*DIST_W-1:0]   ch_dist_i,
    output logic [N_CH-1:0]          ch_ready_o,
    output logic                     mem_we_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DIST_W-1:0]        mem_din_o,
    output logic                     frame_rdy_o,
    output logic                     frame_bank_o,
    input  logic                     rd_done_i,
    output logic [7:0]               overrun_cnt_o,
    output logic [15:0]              frame_cnt_o
);

    localparam bit FULL_ZONES = (ZONES == (1 << ZONE_W));

    state_e                        state_q, state_d;
    logic [N_CH-1:0]               grant;
    logic                          hs, zone_ok, complete, deliver;
    logic [CH_W-1:0]               gch;
    logic [ZONE_W-1:0]             gzone;
    logic [DIST_W-1:0]             gdist;
    logic [N_CH-1:0][ZONES-1:0]    bmap_q, bmap_d;
    logic                          wr_bank_q, wr_bank_d, own_q, own_d, fbank_q, fbank_d;
    logic [7:0]                    ovr_q, ovr_d;
    logic [15:0]                   fcnt_q, fcnt_d;
    logic                          we_q, we_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [DIST_W-1:0]             din_q, din_d;

    tof_rr_arbiter #(.N(N_CH)) u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (ch_valid_i),
        .advance_i (hs),
        .grant_o   (grant)
    );

    assign ch_ready_o = (state_q == FILL && !reset_i) ? grant : '0;
    assign hs         = |ch_ready_o;

    always_comb begin
        gch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) gch = CH_W'(i);
        end
    end

    assign gzone   = ch_zone_i[gch*ZONE_W +: ZONE_W];
    assign gdist   = ch_dist_i[gch*DIST_W +: DIST_W];
    assign zone_ok = FULL_ZONES || (int'(gzone) < ZONES);

    // Disabled channels never block completion; an all-disabled mask never completes.
    always_comb begin
        complete = |ch_en_i;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_en_i[i] && !(&bmap_q[i])) complete = 1'b0;
        end
    end

    // A release arriving in the commit cycle counts before ownership is checked.
    assign deliver = (state_q == COMMIT) && !(own_q && !rd_done_i) && !reset_i;

    always_comb begin
        state_d   = state_q;
        bmap_d    = bmap_q;
        wr_bank_d = wr_bank_q;
        own_d     = own_q && !rd_done_i;
        fbank_d   = fbank_q;
        ovr_d     = ovr_q;
        fcnt_d    = fcnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        if (hs && ch_en_i[gch] && zone_ok) begin
            we_d              = 1'b1;
            addr_d            = AW'(pack_addr(wr_bank_q, int'(gch), int'(gzone), CH_W, ZONE_W));
            din_d             = gdist;
            bmap_d[gch][gzone] = 1'b1;
        end
        case (state_q)
            FILL: if (complete) state_d = COMMIT;
            COMMIT: begin
                state_d = FILL;
                bmap_d  = '0;
                if (deliver) begin
                    own_d     = 1'b1;
                    fbank_d   = wr_bank_q;
                    wr_bank_d = ~wr_bank_q;
                    fcnt_d    = fcnt_q + 16'd1;
                end else if (ovr_q != 8'hFF) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= FILL;
            bmap_q    <= '0;
            wr_bank_q <= 1'b0;
            own_q     <= 1'b0;
            fbank_q   <= 1'b0;
            ovr_q     <= '0;
            fcnt_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            bmap_q    <= bmap_d;
            wr_bank_q <= wr_bank_d;
            own_q     <= own_d;
            fbank_q   <= fbank_d;
            ovr_q     <= ovr_d;
            fcnt_q    <= fcnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_din_o     = din_q;
    assign frame_rdy_o   = deliver;
    assign frame_bank_o  = deliver ? wr_bank_q : fbank_q;
    assign overrun_cnt_o = ovr_q;
    assign frame_cnt_o   = fcnt_q;

endmodule

// File: doc/tof_frame_collector.md
Name: tof_frame_collector

Overview:
Parametrised successor to the single-bus ToF memory-write controller. Accepts zone/distance samples from N_CH ToF channels over per-channel valid/ready handshakes, round-robin arbitrates them onto one BRAM write port, and tracks per-channel zone completion. It writes into a ping-pong frame buffer and hands completed frames to the downstream read FSM (surface and plane calculators), with bank ownership and overrun accounting.

Parameters:
N_CH, 8, number of ToF channels (2..16)
ZONES, 64, zones per channel frame (power of 2, 16 or 64)
DIST_W, 16, distance width in mm
ZONE_W, $clog2(ZONES), derived zone index width; not overridden
CH_W, $clog2(N_CH), derived channel index width; not overridden

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
ch_en  in  N_CH  channel enable mask, sampled every cycle
ch_valid  in  N_CH  per-channel sample valid
ch_zone  in  N_CH*ZONE_W  per-channel zone index, channel i at [i*ZONE_W +: ZONE_W]
ch_dist  in  N_CH*DIST_W  per-channel distance, channel i at [i*DIST_W +: DIST_W]
ch_ready  out  N_CH  per-channel accept (one-hot or zero)
mem_we  out  1  BRAM write enable
mem_addr  out  1+CH_W+ZONE_W  {bank, channel, zone}
mem_din  out  DIST_W  BRAM write data
frame_rdy  out  1  1-cycle pulse: frame complete in frame_bank
frame_bank  out  1  bank handed to reader; held until the next frame_rdy
rd_done  in  1  1-cycle pulse: reader releases its bank
overrun_cnt  out  8  saturating count of frames discarded
frame_cnt  out  16  wrapping count of frames delivered

Behaviour:
- Reset: all outputs 0, wr_bank=0, bitmaps cleared, reader owns no bank, state FILL, RR pointer at channel 0.
- States: FILL and COMMIT. COMMIT lasts exactly one cycle, then the FSM returns to FILL.
- Arbitration in FILL:
  - Among ch_valid, grant the first channel at or after (last_grant+1) mod N_CH.
  - ch_ready = grant, combinational, one-hot. ch_ready is all zero in COMMIT.
  - The pointer advances only on a handshake.
- Handshake at cycle t (valid&ready):
  - Enabled channel with zone<ZONES: at t+1, mem_we=1, mem_addr={wr_bank,ch,zone}, mem_din=dist, and bitmap[ch][zone] set.
  - Disabled channel: sample accepted and dropped, no write.
  - Zone index out of range: dropped. This applies only when ZONES is not 2^ZONE_W, so it is unreachable with the defaults.
- Duplicate zone within a frame: data overwritten in BRAM, bitmap unchanged.
- Completion: every channel with ch_en=1 has all ZONES bits set, and ch_en is not all zero.
  - Evaluated on registered bitmaps. FILL moves to COMMIT the cycle after the final bitmap bit sets, so the final handshake at t gives COMMIT at t+2.
- In COMMIT:
  - Reader owns no bank: pulse frame_rdy, frame_bank=wr_bank, the reader now owns wr_bank, wr_bank flips, frame_cnt++.
  - Reader still owns a bank: no frame_rdy, overrun_cnt++ (saturates at 255), wr_bank unchanged, so the frame is discarded and refilled in place.
  - In both cases all bitmaps clear.
- rd_done:
  - Releases reader ownership.
  - Ignored when the reader owns nothing.
  - rd_done in the COMMIT cycle is applied first, so the frame is delivered with no overrun.
- ch_en changes mid-frame: take effect immediately. A newly disabled channel no longer blocks completion; a newly enabled channel must fill all of its zones.
- Reset mid-frame: discards the frame, clears ownership and counters, and drives mem_we=0 on the next cycle.

Decomposition:
- Package tof_pkg: ZONES/DIST_W/N_CH defaults, address-packing function {bank,ch,zone}, state enum (FILL, COMMIT).
- Sub-module: tof_rr_arbiter. Parameter N; ports req, advance, grant; holds the round-robin pointer.

Test Plan:
- N_CH=2, ZONES=16, both enabled, channels stream zones 0..15 in turn, rd_done never sent:
  - one frame_rdy with frame_bank=0, frame_cnt=1, mem_addr bank bit =0 for all 32 writes;
  - repeating the fill gives overrun_cnt=1, no second frame_rdy, and the next fill writes bank 1.
- All 8 channels hold valid continuously:
  - grants rotate 0,1,...,7,0; exactly one ch_ready per cycle;
  - mem_addr[ZONE_W+CH_W-1:ZONE_W] follows that sequence one cycle later.
- ch_en=8'b0000_0001, channel 0 sends 64 zones with duplicate zone 5 (distance 100 then 200):
  - frame_rdy at last-handshake+2; BRAM zone 5 holds 200;
  - other channels' valid samples are accepted with no mem_we.
- Frame completes with rd_done pulsed in the same cycle as COMMIT (reader holding bank 0):
  - frame_rdy with frame_bank=1, overrun_cnt unchanged.
- Assert reset after 30 of 64 zones, then send a full frame:
  - the only frame_rdy is after the full 64 zones; frame_bank=0; counters restart from 0.
- ch_en=0 with samples streaming:
  - never frame_rdy, never mem_we; all samples accepted.
